// File: rtl/train_pkg.sv
`default_nettype none
// ============================================================================
// Module      : train_pkg
// Description : Shared state encoding, default geometry and coordinate helper
//               for the multi-train track controller.
// Revision    : 1.0 - initial release
// ============================================================================
package train_pkg;

    localparam int c_coord_w  = 10;
    localparam int c_n_trains = 2;
    localparam int c_y_bot    = 422;
    localparam int c_pack_w   = 256;  // widest packed vector: 8 trains x 32 bits

    localparam logic [2*c_coord_w-1:0] c_x_left  = {10'd188, 10'd60};
    localparam logic [2*c_coord_w-1:0] c_x_right = {10'd452, 10'd580};
    localparam logic [2*c_coord_w-1:0] c_y_top   = {10'd180, 10'd60};
    localparam logic [2*c_coord_w-1:0] c_x_start = {10'd320, 10'd320};

    typedef enum logic [2:0] {
        ST_TOP  = 3'd0,
        ST_DOWN = 3'd1,
        ST_GATE = 3'd2,
        ST_BOT  = 3'd3,
        ST_UP   = 3'd4
    } train_state_t;

    // Extract field idx (width bits) from a packed per-train coordinate vector.
    function automatic logic [31:0] coord_slice(input logic [c_pack_w-1:0] vec,
                                                input int width, input int idx);
        logic [c_pack_w-1:0] w_sh;
        w_sh = vec >> (width * idx);
        return w_sh[31:0] & ~(32'hFFFF_FFFF << width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/train_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : train_multi_if
// Description : Control and position bus between a driver and train_multi.
// Revision    : 1.0 - initial release
// ============================================================================
interface train_multi_if
    import train_pkg::*;
#(
    parameter int N_TRAINS = c_n_trains,
    parameter int COORD_W  = c_coord_w,
    parameter int ID_W     = (N_TRAINS > 1) ? $clog2(N_TRAINS) : 1
);

    logic                        step;
    logic [N_TRAINS-1:0]         halt;
    logic [N_TRAINS*COORD_W-1:0] x;
    logic [N_TRAINS*COORD_W-1:0] y;
    logic [N_TRAINS-1:0]         waiting;
    logic                        owner_valid;
    logic [ID_W-1:0]             owner_id;

    modport master (
        output step, halt,
        input  x, y, waiting, owner_valid, owner_id
    );

    modport slave (
        input  step, halt,
        output x, y, waiting, owner_valid, owner_id
    );

endinterface
`default_nettype wire

// File: rtl/train_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : train_rr_arbiter
// Description : Round-robin grant of the shared bottom segment.
// Revision    : 1.0 - initial release
// ============================================================================
module train_rr_arbiter
    import train_pkg::*;
#(
    parameter int N  = c_n_trains,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  wire logic [N-1:0]  req,
    input  wire logic          busy,
    input  wire logic          step,
    input  wire logic [IW-1:0] last_grant,
    output logic      [N-1:0]  grant,
    output logic               grant_valid,
    output logic      [IW-1:0] grant_id
);

    logic [IW-1:0] w_idx;

    // Search begins one past the previous winner; busy blocks any grant so a
    // release and a new grant can never share an edge.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        grant_id    = last_grant;
        w_idx       = '0;
        if (step && !busy) begin
            for (int k = 1; k <= N; k++) begin
                w_idx = IW'((int'(last_grant) + k) % N);
                if (!grant_valid && req[w_idx]) begin
                    grant[w_idx] = 1'b1;
                    grant_valid  = 1'b1;
                    grant_id     = w_idx;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/train_multi.sv
`default_nettype none
// ============================================================================
// Module      : train_multi
// Description : N trains on rectangular loops sharing one bottom row,
//               arbitrated round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module train_multi
    import train_pkg::*;
#(
    parameter int                          N_TRAINS = c_n_trains,
    parameter int                          COORD_W  = c_coord_w,
    parameter int                          Y_BOT    = c_y_bot,
    parameter logic [N_TRAINS*COORD_W-1:0] X_LEFT   = c_x_left,
    parameter logic [N_TRAINS*COORD_W-1:0] X_RIGHT  = c_x_right,
    parameter logic [N_TRAINS*COORD_W-1:0] Y_TOP    = c_y_top,
    parameter logic [N_TRAINS*COORD_W-1:0] X_START  = c_x_start
) (
    input wire logic     clk,
    input wire logic     rst,
    train_multi_if.slave bus
);

    localparam int                 c_id_w = (N_TRAINS > 1) ? $clog2(N_TRAINS) : 1;
    localparam logic [COORD_W-1:0] c_ybot = COORD_W'(Y_BOT);
    localparam logic [COORD_W-1:0] c_gate = COORD_W'(Y_BOT - 1);
    localparam logic [COORD_W-1:0] c_one  = COORD_W'(1);

    logic [N_TRAINS-1:0]         w_req;
    logic [N_TRAINS-1:0]         w_rel;
    logic [N_TRAINS-1:0]         w_grant;
    logic                        w_grant_valid;
    logic [c_id_w-1:0]           w_grant_id;
    logic [N_TRAINS*COORD_W-1:0] w_x_flat;
    logic [N_TRAINS*COORD_W-1:0] w_y_flat;
    logic [N_TRAINS-1:0]         w_waiting;

    logic                        r_owner_valid;
    logic [c_id_w-1:0]           r_owner_id;
    logic [c_id_w-1:0]           r_last_grant;

    train_rr_arbiter #(
        .N  (N_TRAINS),
        .IW (c_id_w)
    ) u_arb (
        .req         (w_req),
        .busy        (r_owner_valid),
        .step        (bus.step),
        .last_grant  (r_last_grant),
        .grant       (w_grant),
        .grant_valid (w_grant_valid),
        .grant_id    (w_grant_id)
    );

    for (genvar gi = 0; gi < N_TRAINS; gi++) begin : g_train
        localparam logic [COORD_W-1:0] c_xl =
            COORD_W'(coord_slice(c_pack_w'(X_LEFT), COORD_W, gi));
        localparam logic [COORD_W-1:0] c_xr =
            COORD_W'(coord_slice(c_pack_w'(X_RIGHT), COORD_W, gi));
        localparam logic [COORD_W-1:0] c_yt =
            COORD_W'(coord_slice(c_pack_w'(Y_TOP), COORD_W, gi));
        localparam logic [COORD_W-1:0] c_xs =
            COORD_W'(coord_slice(c_pack_w'(X_START), COORD_W, gi));

        train_state_t       r_state;
        train_state_t       w_state_nxt;
        logic [COORD_W-1:0] r_x;
        logic [COORD_W-1:0] r_y;
        logic [COORD_W-1:0] w_x_nxt;
        logic [COORD_W-1:0] w_y_nxt;
        logic               r_wait;
        logic               w_wait_nxt;
        logic               w_move;

        assign w_move     = bus.step && !bus.halt[gi];
        // A halted train at its gate does not compete for the segment.
        assign w_req[gi]  = (r_state == ST_GATE) && !bus.halt[gi];
        assign w_rel[gi]  = w_move && (r_state == ST_UP) && (r_y == c_ybot);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= ST_TOP;
                r_x     <= c_xs;
                r_y     <= c_yt;
                r_wait  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_x     <= w_x_nxt;
                r_y     <= w_y_nxt;
                r_wait  <= w_wait_nxt;
            end
        end

        // Corners cost no extra step: the move that lands on a corner also
        // switches direction.
        always_comb begin
            w_state_nxt = r_state;
            w_x_nxt     = r_x;
            w_y_nxt     = r_y;
            w_wait_nxt  = r_wait;
            if (w_move) begin
                case (r_state)
                    ST_TOP: begin
                        w_x_nxt = r_x - c_one;
                        if (w_x_nxt == c_xl) w_state_nxt = ST_DOWN;
                    end
                    ST_DOWN: begin
                        w_y_nxt = r_y + c_one;
                        if (w_y_nxt == c_gate) w_state_nxt = ST_GATE;
                    end
                    ST_GATE: begin
                        if (w_grant[gi]) begin
                            w_y_nxt     = c_ybot;
                            w_state_nxt = ST_BOT;
                            w_wait_nxt  = 1'b0;
                        end else begin
                            w_wait_nxt  = 1'b1;
                        end
                    end
                    ST_BOT: begin
                        w_x_nxt = r_x + c_one;
                        if (w_x_nxt == c_xr) w_state_nxt = ST_UP;
                    end
                    ST_UP: begin
                        w_y_nxt = r_y - c_one;
                        if (w_y_nxt == c_yt) w_state_nxt = ST_TOP;
                    end
                    default: begin
                        w_state_nxt = ST_TOP;
                    end
                endcase
            end
        end

        assign w_x_flat[gi*COORD_W +: COORD_W] = r_x;
        assign w_y_flat[gi*COORD_W +: COORD_W] = r_y;
        assign w_waiting[gi]                   = r_wait;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner_valid <= 1'b0;
            r_owner_id    <= '0;
            r_last_grant  <= c_id_w'(N_TRAINS - 1);
        end else if (w_grant_valid) begin
            r_owner_valid <= 1'b1;
            r_owner_id    <= w_grant_id;
            r_last_grant  <= w_grant_id;
        end else if (|w_rel) begin
            r_owner_valid <= 1'b0;
        end
    end

    assign bus.x           = w_x_flat;
    assign bus.y           = w_y_flat;
    assign bus.waiting     = w_waiting;
    assign bus.owner_valid = r_owner_valid;
    assign bus.owner_id    = r_owner_id;

endmodule
`default_nettype wire

// File: tb/tb_train_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_train_multi
// Description : Directed scoreboard bench for train_multi at default geometry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_train_multi;
    import train_pkg::*;

    localparam int c_budget = 5000;

    typedef struct packed {
        logic [9:0] x0;
        logic [9:0] y0;
        logic [9:0] x1;
        logic [9:0] y1;
        logic [1:0] waiting;
        logic       ov;
        logic       oid;
    } snap_t;

    logic  clk;
    logic  rst;
    int    n_checks;
    int    n_fail;
    int    own_cnt;
    snap_t exp_q[$];
    int    win_q[$];

    train_multi_if #(.N_TRAINS(2), .COORD_W(10), .ID_W(1)) bus ();

    train_multi #(
        .N_TRAINS (2),
        .COORD_W  (10),
        .Y_BOT    (422),
        .X_LEFT   ({10'd188, 10'd60}),
        .X_RIGHT  ({10'd452, 10'd580}),
        .Y_TOP    ({10'd180, 10'd60}),
        .X_START  ({10'd320, 10'd320})
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic snap_t observed();
        snap_t s;
        s.x0      = bus.x[9:0];
        s.y0      = bus.y[9:0];
        s.x1      = bus.x[19:10];
        s.y1      = bus.y[19:10];
        s.waiting = bus.waiting;
        s.ov      = bus.owner_valid;
        s.oid     = bus.owner_id;
        return s;
    endfunction

    function automatic logic at_gate0();
        return (bus.x[9:0] == 10'd60) && (bus.y[9:0] == 10'd421);
    endfunction

    function automatic logic at_gate1();
        return (bus.x[19:10] == 10'd188) && (bus.y[19:10] == 10'd421);
    endfunction

    task automatic drive(input logic s, input logic [1:0] h);
        bus.step = s;
        bus.halt = h;
        @(negedge clk);
    endtask

    task automatic run(input int n, input logic [1:0] h);
        for (int i = 0; i < n; i++) drive(1'b1, h);
    endtask

    task automatic push(input int x0, input int y0, input int x1, input int y1,
                        input logic [1:0] w, input logic ov, input logic oid);
        snap_t s;
        s.x0 = 10'(x0); s.y0 = 10'(y0); s.x1 = 10'(x1); s.y1 = 10'(y1);
        s.waiting = w; s.ov = ov; s.oid = oid;
        exp_q.push_back(s);
    endtask

    task automatic check_next(input string tag);
        snap_t e;
        snap_t o;
        o = observed();
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            assert (o === e) else begin
                n_fail++;
                $error("FAIL %s observed x0=%0d y0=%0d x1=%0d y1=%0d wait=%b ov=%b id=%0d expected x0=%0d y0=%0d x1=%0d y1=%0d wait=%b ov=%b id=%0d",
                       tag, o.x0, o.y0, o.x1, o.y1, o.waiting, o.ov, o.oid,
                       e.x0, e.y0, e.x1, e.y1, e.waiting, e.ov, e.oid);
            end
        end
    endtask

    task automatic check_val(input string tag, input int obs, input int expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Park each train at its gate, then release both on one step.
    task automatic contend(input string tag);
        int          cnt;
        int          w;
        logic [1:0]  h;
        cnt = 0;
        while (!(at_gate0() && at_gate1() && !bus.owner_valid) && cnt < c_budget) begin
            h = {at_gate1(), at_gate0()};
            drive(1'b1, h);
            cnt++;
        end
        check_val({tag, "_reach_gates"}, int'(cnt < c_budget), 1);
        drive(1'b1, 2'b00);
        w = win_q.pop_front();
        check_val({tag, "_owner_valid"}, int'(bus.owner_valid), 1);
        check_val({tag, "_owner_id"}, int'(bus.owner_id), w);
        check_val({tag, "_waiting"}, int'(bus.waiting), (w == 0) ? 2 : 1);
        check_val({tag, "_winner_y"}, (w == 0) ? int'(bus.y[9:0]) : int'(bus.y[19:10]), 422);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.step = 1'b0;
        bus.halt = 2'b00;
        repeat (2) @(negedge clk);

        push(320, 60, 320, 180, 2'b00, 1'b0, 1'b0);
        check_next("reset_values");
        rst = 1'b0;
        push(320, 60, 320, 180, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b0, 2'b00);
        check_next("no_step_idle");

        // Train 0 alone for a full lap, train 1 halted.
        push(60, 60, 320, 180, 2'b00, 1'b0, 1'b0);
        run(260, 2'b10);
        check_next("solo_top_left");
        push(60, 421, 320, 180, 2'b00, 1'b0, 1'b0);
        run(361, 2'b10);
        check_next("solo_at_gate");
        push(60, 422, 320, 180, 2'b00, 1'b1, 1'b0);
        drive(1'b1, 2'b10);
        check_next("solo_enter_bottom");
        own_cnt = int'(bus.owner_valid);
        for (int i = 0; i < 1142; i++) begin
            drive(1'b1, 2'b10);
            own_cnt += int'(bus.owner_valid);
        end
        check_val("solo_owner_steps", own_cnt, 521);
        push(320, 60, 320, 180, 2'b00, 1'b0, 1'b0);
        check_next("solo_lap_return");

        // Reset re-arms the pointer so train 0 wins the tie.
        rst = 1'b1;
        drive(1'b0, 2'b00);
        rst = 1'b0;
        push(320, 60, 320, 180, 2'b00, 1'b0, 1'b0);
        check_next("reset_after_lap");

        push(72, 60, 320, 180, 2'b00, 1'b0, 1'b0);
        run(248, 2'b10);
        check_next("align_train0");
        push(60, 421, 188, 421, 2'b00, 1'b0, 1'b0);
        run(373, 2'b00);
        check_next("both_at_gate");
        push(60, 422, 188, 421, 2'b10, 1'b1, 1'b0);
        drive(1'b1, 2'b00);
        check_next("tie_train0_wins");
        push(160, 422, 188, 421, 2'b10, 1'b1, 1'b0);
        run(100, 2'b00);
        check_next("bottom_progress");
        push(160, 422, 188, 421, 2'b10, 1'b1, 1'b0);
        run(50, 2'b01);
        check_next("halted_owner_frozen");
        push(580, 422, 188, 421, 2'b10, 1'b1, 1'b0);
        run(420, 2'b00);
        check_next("bottom_right_corner");
        push(580, 421, 188, 421, 2'b10, 1'b0, 1'b0);
        drive(1'b1, 2'b00);
        check_next("release_first_up");
        // Entry lands on the step after the release step.
        push(580, 420, 188, 422, 2'b00, 1'b1, 1'b1);
        drive(1'b1, 2'b00);
        check_next("train1_enters");

        win_q.push_back(0);
        win_q.push_back(1);
        win_q.push_back(0);
        win_q.push_back(1);
        contend("rr0");
        contend("rr1");
        contend("rr2");
        contend("rr3");

        // Train 1 owns the segment here.
        rst = 1'b1;
        drive(1'b1, 2'b00);
        rst = 1'b0;
        push(320, 60, 320, 180, 2'b00, 1'b0, 1'b0);
        check_next("reset_mid_owner");
        win_q.push_back(0);
        contend("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
